// File: rtl/screen_sequencer.sv
// Output multiplexer and sequencer for the VGA pixel port: forwards game pixels,
// clears the screen on a win, hands over to the banner drawer, then holds until restart.
module screen_sequencer #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       fastclock,
  input  logic       resetn,
  input  logic       win,
  input  logic       restart,
  input  logic [7:0] game_x,
  input  logic [6:0] game_y,
  input  logic [2:0] game_colour,
  input  logic       game_plot,
  input  logic [7:0] ban_x,
  input  logic [6:0] ban_y,
  input  logic [2:0] ban_colour,
  input  logic       ban_plot,
  input  logic       ban_done,
  output logic       ban_start,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [1:0] mode,
  output logic       busy
);

  localparam int CX_W = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int CY_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SCREEN_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_GAME   = 2'd0,
    S_CLEAR  = 2'd1,
    S_BANNER = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t          state;
  logic            run_q;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            cx_last;
  logic            cy_last;

  assign cx_last = (cx == CX_LAST);
  assign cy_last = (cy == CY_LAST);

  assign mode = state;
  assign busy = (state == S_CLEAR) || (state == S_BANNER);

  // run_q spends the first edge after reset release idle, so a release that lands
  // close to an edge can never let half the flops leave reset on a different cycle.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values of each other; blocking assignments would chain updates.
  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_GAME;
      run_q     <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      ban_start <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      ban_start <= 1'b0;
      plot      <= 1'b0;
      case (state)
        S_GAME: begin
          x      <= game_x;
          y      <= game_y;
          colour <= game_colour;
          plot   <= game_plot;
          if (win) begin
            state <= S_CLEAR;
            cx    <= '0;
            cy    <= '0;
          end
        end
        S_CLEAR: begin
          x      <= 8'(cx);
          y      <= 7'(cy);
          colour <= CLEAR_COLOUR;
          plot   <= 1'b1;
          if (cx_last) begin
            cx <= '0;
            if (cy_last) begin
              cy        <= '0;
              state     <= S_BANNER;
              ban_start <= 1'b1;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        S_BANNER: begin
          // The pixel arriving alongside ban_done is the banner's final one.
          x      <= ban_x;
          y      <= ban_y;
          colour <= ban_colour;
          plot   <= ban_plot;
          if (ban_done) state <= S_HOLD;
        end
        S_HOLD: begin
          if (restart) state <= S_GAME;
        end
        default: state <= S_GAME;
      endcase
    end
  end

endmodule
